conv_out_mem_write: RTL
=======================

# conv_out_mem_write

Write-side address generator and data stager for one conv1 output feature map (24×24 = 576 pixels). Four parallel result lanes each own one quarter of the map: 6 output rows × 24 pixels = 144 pixels per lane, at base offsets 0, 144, 288 and 432. The block accepts one result per lane per valid strobe from the conv1 MAC array and issues a single write to the output-map memory. It applies optional ReLU, counts completed pixels, and asserts done after the last write.

## Interface
Parameters:
- DATA_W, 16, signed result width per lane
- RELU, 1, 1 = clamp negative results to 0 before writing; 0 = pass through unchanged

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  block may accept results while high
- valid  in  1  data0..data3 hold one new result each
- data0..data3  in  DATA_W each  signed results, lanes 0..3
- we  out  1  write enable to the output memory
- addr0..addr3  out  10 each  write addresses, lanes 0..3
- wdata0..wdata3  out  DATA_W each  write data, lanes 0..3
- done  out  1  all 576 pixels written; sticky until reset
- overflow  out  1  sticky; valid arrived while in DONE

## Operation
- All registers update on the falling edge of clk. The memory samples we/addr/wdata on the rising edge.
- Internal pixel counter n spans 0..144 and needs 8 bits.
- States and transitions:
  - RUN: the state after reset.
  - RUN→DONE: taken when n==144 and we==0.
  - DONE: held until reset.
- Accept condition: state==RUN and enable==1 and valid==1 and n<144.
- On accept:
  - we<=1
  - addrk<=BASEk+n, where BASE = 0, 144, 288, 432
  - wdatak<=f(datak), where f(x) = (RELU && x<0) ? 0 : x
  - n<=n+1
- Without accept: we<=0; addrk and wdatak hold their values.
- Back-to-back valids are accepted every cycle. We stays high and addresses advance by 1 per cycle.
- enable low pauses the block. Valid is ignored and not queued, and n, addresses and data hold.
- Valid in DONE is ignored: no write is issued. It sets overflow<=1.
- Valid in RUN with n==144 (the final write is still pending) is ignored and does not set overflow.
- Address arithmetic is 10-bit unsigned and never wraps. The maximum address is 575 (lane 3, n=143).
- Pixel order within a lane is raster: address BASEk+n corresponds to lane row n/24 and column n%24.

## Timing
- Reset values:
  - we=0, done=0, overflow=0
  - addr0=0, addr1=144, addr2=288, addr3=432
  - wdata0..3=0, n=0, state RUN
- Reset mid-operation immediately restores all reset values. Partially written memory contents are not cleared.
- Latency: valid/data are sampled at falling edge k. At the next rising edge (half a cycle later), memory sees we=1 with the addressed data.
- The upstream source holds valid/data stable across the falling edge only; no ready/backpressure is provided.
- We is high for exactly one cycle per accepted result.
- Done: the final accept sets n=144 and we=1. At the next falling edge, we falls to 0. At the falling edge after that, state goes to DONE and done=1. Done therefore rises 2 cycles after the 144th accept.
- Done and overflow are registered; they never go high combinationally.

## Test plan
- Reset check: assert reset asynchronously mid-cycle → outputs show addr=0/144/288/432, we=0, done=0, overflow=0 with no clock edge required.
- Streaming: 144 consecutive valids with data0..3 = n, n+1000, n+2000, n+3000 (RELU=0) →
  - we is high for 144 consecutive cycles
  - final writes land at 143/287/431/575
  - done rises 2 cycles after the last accept
  - memory model contents match the inputs
- Gapped stimulus: valid pulses every 3rd cycle, and enable is dropped for 10 cycles with valid high mid-stream → no writes occur while enable is low; addresses stay contiguous; exactly 144 writes occur per lane.
- ReLU: RELU=1 with data0=-5, data1=0, data2=7, data3=-32768 → written values are 0, 0, 7, 0. With RELU=0, the same stimulus writes the values unchanged.
- Overflow: after done, pulse valid with data=0x1234 → we stays 0, overflow=1, and memory is unchanged. A subsequent reset clears overflow and done.
- Mid-run reset: reset after 50 accepts, then stream 144 more → addresses restart at 0/144/288/432 and done rises after exactly 144 further accepts.

Source files
------------

// File: rtl/conv_out_mem_write.sv
// ---------------------------------------------------------------------------
// conv_out_mem_write
//
// Write-side address generator and data stager for one 24x24 conv1 output
// feature map (576 pixels). The map is split into four horizontal quarters,
// one per result lane. Each lane covers 6 rows x 24 pixels = 144 pixels,
// starting at base offsets 0, 144, 288 and 432. Every accepted valid strobe
// produces one write per lane in a single memory cycle.
//
// Registers update on the falling edge of clk. The output memory samples
// we/addr/wdata on the rising edge, so a result sampled at one falling edge
// is written half a cycle later.
//
// Parameters:
//   DATA_W   signed result width per lane
//   RELU     1 = negative results are written as 0, 0 = pass through
//
// Ports:
//   clk            system clock (state changes on the falling edge)
//   reset          asynchronous, active-high reset
//   enable         block may accept results while high
//   valid          data0..data3 hold one new result each
//   data0..data3   signed results for lanes 0..3
//   we             write enable to the output memory
//   addr0..addr3   10-bit write addresses for lanes 0..3
//   wdata0..wdata3 write data for lanes 0..3
//   done           all 576 pixels written; sticky until reset
//   overflow       sticky; a valid arrived after the map was complete
// ---------------------------------------------------------------------------
module conv_out_mem_write #(
  parameter int DATA_W = 16,
  parameter bit RELU   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] data0,
  input  logic signed [DATA_W-1:0] data1,
  input  logic signed [DATA_W-1:0] data2,
  input  logic signed [DATA_W-1:0] data3,
  output logic                     we,
  output logic [9:0]               addr0,
  output logic [9:0]               addr1,
  output logic [9:0]               addr2,
  output logic [9:0]               addr3,
  output logic signed [DATA_W-1:0] wdata0,
  output logic signed [DATA_W-1:0] wdata1,
  output logic signed [DATA_W-1:0] wdata2,
  output logic signed [DATA_W-1:0] wdata3,
  output logic                     done,
  output logic                     overflow
);

  localparam int         LANES           = 4;
  localparam logic [7:0] PIXELS_PER_LANE = 8'd144;

  // First address of each lane's quarter of the map.
  localparam logic [9:0] LANE_BASE [LANES] = '{10'd0, 10'd144, 10'd288, 10'd432};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 pixelCount_q, pixelCount_d;
  logic                       we_q, we_d;
  logic [9:0]                 addr_q  [LANES];
  logic [9:0]                 addr_d  [LANES];
  logic signed [DATA_W-1:0]   wdata_q [LANES];
  logic signed [DATA_W-1:0]   wdata_d [LANES];
  logic                       done_q, done_d;
  logic                       overflow_q, overflow_d;

  logic signed [DATA_W-1:0]   dataLane [LANES];
  logic                       accept;

  // Gather the four lane inputs into an array so the per-lane logic can be
  // written once as a loop.
  assign dataLane[0] = data0;
  assign dataLane[1] = data1;
  assign dataLane[2] = data2;
  assign dataLane[3] = data3;

  // Optional ReLU: only the sign bit matters, so negative results collapse to
  // zero and everything else is forwarded untouched.
  function automatic logic signed [DATA_W-1:0] applyRelu(input logic signed [DATA_W-1:0] x);
    if (RELU && x[DATA_W-1]) begin
      return '0;
    end
    return x;
  endfunction

  // A result is taken only while running with room left in the lane. Once the
  // counter reaches 144 the final write may still be on the bus, so further
  // valids are simply dropped without flagging overflow.
  assign accept = (state_q == ST_RUN) && enable && valid && (pixelCount_q < PIXELS_PER_LANE);

  // Next-state logic. Write enable defaults low so it is a single-cycle pulse
  // per accepted result; addresses and data hold between writes. The move to
  // DONE waits until the last write has left the bus (we_q low), which puts
  // done two cycles after the final accept.
  always_comb begin
    state_d      = state_q;
    pixelCount_d = pixelCount_q;
    we_d         = 1'b0;
    done_d       = done_q;
    overflow_d   = overflow_q;
    for (int k = 0; k < LANES; k++) begin
      addr_d[k]  = addr_q[k];
      wdata_d[k] = wdata_q[k];
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          we_d         = 1'b1;
          pixelCount_d = pixelCount_q + 8'd1;
          for (int k = 0; k < LANES; k++) begin
            addr_d[k]  = LANE_BASE[k] + {2'b00, pixelCount_q};
            wdata_d[k] = applyRelu(dataLane[k]);
          end
        end else if ((pixelCount_q == PIXELS_PER_LANE) && !we_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (valid) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register, clocked on the falling edge so the memory sees stable
  // write signals at its rising-edge sample point. Reset restores the lane
  // base addresses rather than zero so the address bus is meaningful
  // immediately after reset.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pixelCount_q <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        addr_q[k]  <= LANE_BASE[k];
        wdata_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pixelCount_q <= pixelCount_d;
      we_q         <= we_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      for (int k = 0; k < LANES; k++) begin
        addr_q[k]  <= addr_d[k];
        wdata_q[k] <= wdata_d[k];
      end
    end
  end

  // Everything visible on the ports comes straight from registers.
  assign we       = we_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign addr0    = addr_q[0];
  assign addr1    = addr_q[1];
  assign addr2    = addr_q[2];
  assign addr3    = addr_q[3];
  assign wdata0   = wdata_q[0];
  assign wdata1   = wdata_q[1];
  assign wdata2   = wdata_q[2];
  assign wdata3   = wdata_q[3];

endmodule
